// File: rtl/hier_node_sequencer.sv
// hier_node_sequencer
//   Runs a group of child blocks either one after another (sequential mode)
//   or all together (parallel mode). Each wait on the children can be
//   bounded by a programmable timeout.
//
// Parameters
//   NUM_CHILDREN  number of children controlled (1..32)
//   TO_W          width of the per-wait timeout counter
//   IDX_W         width of a child index
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start_i        one-cycle run request, taken only when idle
//   mode_i         sampled with start_i: 0 = sequential, 1 = parallel
//   timeout_i      wait limit in cycles, sampled with start_i; 0 = no limit
//   child_start_o  registered one-cycle start pulse per child
//   child_done_i   one-cycle completion pulse per child
//   busy_o         high whenever a run is in progress
//   done_o         one-cycle pulse when the run completes
//   error_o        one-cycle pulse when a wait times out
//   err_idx_o      child that timed out; cleared by the next start
module hier_node_sequencer #(
  parameter int NUM_CHILDREN = 5,
  parameter int TO_W         = 8,
  parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [TO_W-1:0]         timeout_i,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [IDX_W-1:0]        err_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t                  state;
  logic                    mode_q;
  logic [TO_W-1:0]         to_q;
  logic [TO_W-1:0]         cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_CHILDREN-1:0] mask_q;

  logic [NUM_CHILDREN-1:0] idx_onehot;
  logic [NUM_CHILDREN-1:0] accept;
  logic [NUM_CHILDREN-1:0] mask_nx;
  logic                    exit_ok;
  logic                    is_last;
  logic                    timed_out;
  logic [IDX_W-1:0]        first_clr;
  logic                    found;

  // In sequential mode only the launched child may set its mask bit.
  assign idx_onehot = NUM_CHILDREN'(1) << idx_q;
  assign accept     = mode_q ? '1 : idx_onehot;
  assign mask_nx    = mask_q | (child_done_i & accept);

  // Exit uses the mask including this cycle's pulses, so a done that lands on
  // the timeout cycle still wins.
  assign exit_ok   = mode_q ? (&mask_nx) : (|(mask_nx & idx_onehot));
  assign is_last   = (idx_q == IDX_W'(NUM_CHILDREN - 1));
  assign timed_out = (to_q != '0) && (cnt_q == to_q);

  // Lowest child still outstanding, reported on a parallel-mode timeout.
  always_comb begin
    first_clr = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
      if (!found && !mask_nx[i]) begin
        first_clr = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= 1'b0;
      to_q          <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      mask_q        <= '0;
      child_start_o <= '0;
      err_idx_o     <= '0;
    end else begin
      child_start_o <= '0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mode_q        <= mode_i;
            to_q          <= timeout_i;
            idx_q         <= '0;
            mask_q        <= '0;
            err_idx_o     <= '0;
            // Start pulse is loaded on entry so it is visible during LAUNCH.
            child_start_o <= mode_i ? '1 : NUM_CHILDREN'(1);
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          mask_q <= mask_nx;
          cnt_q  <= cnt_q + TO_W'(1);
          if (exit_ok) begin
            if (mode_q || is_last) begin
              state <= S_FINISH;
            end else begin
              idx_q         <= idx_q + IDX_W'(1);
              child_start_o <= idx_onehot << 1;
              state         <= S_LAUNCH;
            end
          end else if (timed_out) begin
            err_idx_o <= mode_q ? first_clr : idx_q;
            state     <= S_FAIL;
          end
        end
        S_FINISH: state <= S_IDLE;
        S_FAIL:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state != S_IDLE);
  assign done_o  = (state == S_FINISH);
  assign error_o = (state == S_FAIL);

endmodule

// File: tb/tb_hier_node_sequencer.sv
// tb_hier_node_sequencer
//   Self-checking bench for hier_node_sequencer (5 children, 8-bit timeout).
//   For each run a reference timeline is computed from per-child response
//   delays: launch cycles, done-pulse cycles, the completion or timeout cycle
//   and the reported child. The same timeline drives child_done_i and gives
//   the expected value of every output on every cycle.
module tb_hier_node_sequencer;

  localparam int N    = 5;
  localparam int TW   = 8;
  localparam int IW   = 3;
  localparam int MAXC = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          mode_i;
  logic [TW-1:0] timeout_i;
  logic [N-1:0]  child_start_o;
  logic [N-1:0]  child_done_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [IW-1:0] err_idx_o;

  always #5 clk = ~clk;

  hier_node_sequencer #(
    .NUM_CHILDREN(N),
    .TO_W        (TW),
    .IDX_W       (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .timeout_i    (timeout_i),
    .child_start_o(child_start_o),
    .child_done_i (child_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_idx_o    (err_idx_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference timeline for one run; cycle 0 is the cycle start_i is driven.
  bit [N-1:0]  e_start   [MAXC];
  bit          e_busy    [MAXC];
  bit          e_done    [MAXC];
  bit          e_err     [MAXC];
  bit [IW-1:0] e_eidx    [MAXC];
  bit [N-1:0]  d_done    [MAXC];
  int          cur_child [MAXC];
  int          run_end;
  int          dly [N];
  bit          run_mode;
  int          run_to;
  bit [IW-1:0] prev_eidx;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sequential: child k is launched at s_k; its done, d_k cycles later, is
  // accepted when no limit is set or d_k <= T+1, and the next launch follows
  // one cycle after it. A late child fails at s_k+T+2.
  // Parallel: one launch at cycle 1; completion one cycle after the slowest
  // child, or a failure at T+3 naming the lowest late child.
  task automatic build_run(bit md, int to);
    int  s;
    int  seg_end;
    int  maxd;
    int  fidx;
    bit  ok;
    bit  found;
    for (int c = 0; c < MAXC; c++) begin
      e_start[c]   = '0;
      e_busy[c]    = 1'b0;
      e_done[c]    = 1'b0;
      e_err[c]     = 1'b0;
      e_eidx[c]    = '0;
      d_done[c]    = '0;
      cur_child[c] = -1;
    end
    run_mode = md;
    run_to   = to;
    ok       = 1'b1;
    fidx     = 0;
    run_end  = 0;
    if (!md) begin
      s = 1;
      for (int k = 0; k < N; k++) begin
        e_start[s] = N'(1) << k;
        if (to == 0 || dly[k] <= to + 1) begin
          seg_end = s + dly[k];
          d_done[seg_end][k] = 1'b1;
          for (int c = s; c <= seg_end; c++) cur_child[c] = k;
          s = seg_end + 1;
          if (k == N - 1) run_end = s;
        end else begin
          ok      = 1'b0;
          fidx    = k;
          run_end = s + to + 2;
          for (int c = s; c <= run_end; c++) cur_child[c] = k;
          break;
        end
      end
    end else begin
      e_start[1] = '1;
      maxd = 0;
      for (int j = 0; j < N; j++) if (dly[j] > maxd) maxd = dly[j];
      if (to == 0 || maxd <= to + 1) begin
        run_end = maxd + 2;
        for (int j = 0; j < N; j++) d_done[1 + dly[j]][j] = 1'b1;
      end else begin
        ok      = 1'b0;
        run_end = to + 3;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (dly[j] <= to + 1) d_done[1 + dly[j]][j] = 1'b1;
          else if (!found) begin
            fidx  = j;
            found = 1'b1;
          end
        end
      end
    end
    for (int c = 1; c <= run_end; c++) e_busy[c] = 1'b1;
    e_done[run_end] = ok;
    e_err[run_end]  = !ok;
    e_eidx[0]       = prev_eidx;
    e_eidx[run_end] = ok ? '0 : IW'(fidx);
  endtask

  task automatic cmp_cycle(int c);
    check("child_start", 32'(child_start_o), 32'(e_start[c]));
    check("busy",        32'(busy_o),        32'(e_busy[c]));
    check("done",        32'(done_o),        32'(e_done[c]));
    check("error",       32'(error_o),       32'(e_err[c]));
    check("err_idx",     32'(err_idx_o),     32'(e_eidx[c]));
  endtask

  task automatic cmp_idle(bit [IW-1:0] eidx);
    check("idle_child_start", 32'(child_start_o), 32'd0);
    check("idle_busy",        32'(busy_o),        32'd0);
    check("idle_done",        32'(done_o),        32'd0);
    check("idle_error",       32'(error_o),       32'd0);
    check("idle_err_idx",     32'(err_idx_o),     32'(eidx));
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic exec_run(bit noise, int abort_at);
    int j;
    for (int c = 0; c <= run_end; c++) begin
      if (c == abort_at) begin
        rst          = 1'b1;
        start_i      = 1'b0;
        child_done_i = '1;
        @(negedge clk);
        cmp_cycle(c);
        @(posedge clk); #1;
        child_done_i = N'($urandom);
        start_i      = 1'b1;
        @(negedge clk);
        cmp_idle('0);
        @(posedge clk); #1;
        rst          = 1'b0;
        start_i      = 1'b0;
        child_done_i = '0;
        @(negedge clk);
        cmp_idle('0);
        @(posedge clk); #1;
        prev_eidx = '0;
        return;
      end
      start_i      = (c == 0) ? 1'b1 : (noise && ($urandom % 6 == 0));
      mode_i       = (c == 0) ? run_mode : 1'($urandom);
      timeout_i    = (c == 0) ? TW'(run_to) : TW'($urandom);
      child_done_i = d_done[c];
      // A pulse from any child other than the one being waited on is ignored.
      if (noise && !run_mode && ($urandom % 4 == 0)) begin
        j = int'($urandom % N);
        if (j != cur_child[c]) child_done_i[j] = 1'b1;
      end
      @(negedge clk);
      cmp_cycle(c);
      @(posedge clk); #1;
    end
    prev_eidx    = e_eidx[run_end];
    start_i      = 1'b0;
    child_done_i = '0;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      start_i      = 1'b0;
      mode_i       = 1'($urandom);
      timeout_i    = TW'($urandom);
      child_done_i = N'($urandom);
      @(negedge clk);
      cmp_idle(prev_eidx);
      @(posedge clk); #1;
    end
    child_done_i = '0;
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    mode_i       = 1'b0;
    timeout_i    = '0;
    child_done_i = '0;
    prev_eidx    = '0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      cmp_idle('0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Sequential, every child answers 3 cycles after its start.
    dly = '{3, 3, 3, 3, 3};
    build_run(1'b0, 0);
    check("pin_seq_start0",  32'(e_start[1]),  32'h01);
    check("pin_seq_start1",  32'(e_start[5]),  32'h02);
    check("pin_seq_start4",  32'(e_start[17]), 32'h10);
    check("pin_seq_end",     32'(run_end),     32'd21);
    exec_run(1'b0, -1);
    idle_cycles(1);

    // Parallel, arrivals 4, 0, then 1 and 2 together, then 3.
    dly = '{2, 3, 3, 5, 1};
    build_run(1'b1, 0);
    check("pin_par_start",   32'(e_start[1]),  32'h1f);
    check("pin_par_end",     32'(run_end),     32'd7);
    exec_run(1'b0, -1);
    idle_cycles(1);

    // Sequential timeout 4, child 2 never answers.
    dly = '{1, 1, 60, 1, 1};
    build_run(1'b0, 4);
    check("pin_to_end",      32'(run_end),     32'd11);
    check("pin_to_err",      32'(e_err[11]),   32'd1);
    check("pin_to_eidx",     32'(e_eidx[11]),  32'd2);
    check("pin_to_no_start3",32'(e_start[7] | e_start[9] | e_start[11]), 32'd0);
    exec_run(1'b0, -1);
    idle_cycles(2);

    // Done on exactly the timeout cycle wins, both modes.
    dly = '{5, 5, 5, 5, 5};
    build_run(1'b0, 4);
    check("pin_edge_seq_end",  32'(run_end),    32'd31);
    check("pin_edge_seq_done", 32'(e_done[31]), 32'd1);
    exec_run(1'b0, -1);
    dly = '{4, 1, 2, 3, 4};
    build_run(1'b1, 3);
    check("pin_edge_par_end",  32'(run_end),    32'd6);
    check("pin_edge_par_done", 32'(e_done[6]),  32'd1);
    exec_run(1'b0, -1);
    idle_cycles(1);

    // Start requests while busy plus stray pulses from other children.
    dly = '{4, 2, 5, 3, 2};
    build_run(1'b0, 0);
    exec_run(1'b1, -1);

    // Reset in the middle of child 1's wait, then a clean rerun.
    dly = '{2, 4, 3, 3, 3};
    build_run(1'b0, 0);
    exec_run(1'b0, 6);
    build_run(1'b0, 0);
    exec_run(1'b0, -1);
    idle_cycles(1);

    // Random runs, including back-to-back starts on the first idle cycle.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) dly[k] = int'($urandom_range(9, 1));
      build_run(1'($urandom), ($urandom % 3 == 0) ? 0 : int'($urandom_range(6, 1)));
      exec_run(1'b1, -1);
      idle_cycles(int'($urandom % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hier_node_sequencer.md
HIER_NODE_SEQUENCER -- requirements
Module: hier_node_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHILDREN, default 5, number of child instances controlled (range 1..32).
REQ-002 SHALL have parameter TO_W, default 8, width of the per-wait timeout counter.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_CHILDREN) with a minimum of 1, width of the child index.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start_i, input, 1, one-cycle request to run a sequence.
REQ-007 SHALL have port mode_i, input, 1, sampled with start_i: 0 = sequential, 1 = parallel.
REQ-008 SHALL have port timeout_i, input, TO_W, wait limit in cycles; 0 disables the timeout.
REQ-009 SHALL have port child_start_o, output, NUM_CHILDREN, one-cycle start pulse per child.
REQ-010 SHALL have port child_done_i, input, NUM_CHILDREN, one-cycle completion pulse per child.
REQ-011 SHALL have port busy_o, output, 1, high in any state except IDLE.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse on successful completion.
REQ-013 SHALL have port error_o, output, 1, one-cycle pulse on timeout.
REQ-014 SHALL have port err_idx_o, output, IDX_W, index of the child that timed out; held until the next start.

Function
REQ-015 SHALL implement the FSM states IDLE, LAUNCH, WAIT, FINISH and FAIL.
REQ-016 In IDLE, start_i=1 SHALL latch mode_i and timeout_i, clear the index and done mask, and go to LAUNCH next cycle. start_i in any other state SHALL be ignored.
REQ-017 In LAUNCH, sequential mode SHALL assert child_start_o[idx] for exactly one cycle; parallel mode SHALL assert all bits for one cycle. LAUNCH always goes to WAIT.
REQ-018 In WAIT, each child_done_i bit SHALL be OR-ed into a sticky done mask. Done pulses from non-launched children SHALL be ignored in sequential mode.
REQ-019 In sequential mode, WAIT SHALL exit when mask[idx] is set: if idx == NUM_CHILDREN-1 go to FINISH, otherwise increment idx and go to LAUNCH. Start-to-start spacing with an immediate done is therefore 2 cycles.
REQ-020 In parallel mode, WAIT SHALL go to FINISH when the mask is all-ones. Bits may arrive in any order, including the same cycle.
REQ-021 The timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle. When the counter equals the latched timeout (nonzero) with the exit condition false, the FSM SHALL go to FAIL. If done and timeout coincide, done SHALL win.
REQ-022 On the FAIL transition, err_idx_o SHALL capture, in sequential mode, idx; in parallel mode, the lowest index with its mask bit clear.
REQ-023 FINISH SHALL pulse done_o for one cycle and return to IDLE. FAIL SHALL pulse error_o for one cycle and return to IDLE.
REQ-024 busy_o SHALL deassert in the cycle after done_o or error_o. A new start_i is accepted in that IDLE cycle.
REQ-025 child_start_o SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 While rst=1, the next state SHALL be IDLE and child_start_o=0, busy_o=0, done_o=0, error_o=0, err_idx_o=0, with idx, mask and counter cleared.
REQ-027 Reset asserted mid-sequence SHALL abort with no further start pulses. Child done pulses during reset SHALL be discarded.

Verification
REQ-028 Sequential, N=5, each child done 3 cycles after its start -> child_start_o pulses 1,2,4,8,16 in order; one done_o; zero error_o.
REQ-029 Parallel, N=5, done bits arrive in the order 4,0,2 (same cycle as 1),3 -> a single child_start_o=0x1F; done_o 1 cycle after the last bit arrives.
REQ-030 Sequential, timeout_i=4, child 2 never done -> error_o pulse, err_idx_o=2, no start to child 3, busy_o low on the next cycle.
REQ-031 Timeout boundary, done arrives in the same cycle the counter reaches timeout_i -> done path taken, no error_o.
REQ-032 rst asserted in WAIT of child 1, then start again -> restarts at child 0; all outputs 0 during reset.
REQ-033 start_i while busy, plus a spurious done from child 3 while waiting on child 0 (sequential) -> both ignored; sequence completes normally.
